flo12_rr_arb: RTL

- 12-requester round-robin arbiter for a shared resource; one owner at a time.
- Priority search uses find-last-one: highest set index wins, rotated by the previous grant.
- Holds the grant until the owner signals done, drops its request, or a hold timeout expires.
- Sits in front of shared utility datapaths (multiplier, divider, memory port) that accept one client at a time.

---
 rtl/flo12_rr_arb_pkg.sv | 24 ++
 rtl/flo12_rr_arb_flo.sv | 18 +
 rtl/flo12_rr_arb.sv | 121 ++++++++++++
 3 files changed

// File: rtl/flo12_rr_arb_pkg.sv
// Shared types and constants for the 12-requester round-robin arbiter.
// Optional lock input is enabled by defining FLO12_RR_ARB_LOCK_EN.
package flo12_rr_arb_pkg;

   localparam int unsigned NREQ = 12;
   localparam logic [3:0]  NONE = 4'd15;

   typedef enum logic [0:0] {
      StIdle,
      StGrant
   } state_e;

   // Mask of indices strictly below the previous grant; NONE means no history.
   function automatic logic [NREQ-1:0] below_mask(input logic [3:0] last);
      logic [NREQ-1:0] mask;
      if (last == NONE) begin
         mask = '1;
      end else begin
         mask = (NREQ'(1) << last) - NREQ'(1);
      end
      return mask;
   endfunction

endpackage

// File: rtl/flo12_rr_arb_flo.sv
// Find-last-one encoder: index of the highest set bit, NONE when no bit is set.
module flo12_rr_arb_flo
   import flo12_rr_arb_pkg::*;
(
   input  logic [NREQ-1:0] vec,
   output logic [3:0]      idx
);

   always_comb begin
      idx = NONE;
      for (int i = 0; i < NREQ; i++) begin
         if (vec[i]) begin
            idx = 4'(i);
         end
      end
   end

endmodule

// File: rtl/flo12_rr_arb.sv
// Round-robin arbiter for 12 requesters with descending priority and hold timeout.
// Define FLO12_RR_ARB_LOCK_EN to add the lock input that pins the current grant.
module flo12_rr_arb
   import flo12_rr_arb_pkg::*;
#(
   parameter int unsigned TMO  = 0,
   parameter int unsigned TMOW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            done,
`ifdef FLO12_RR_ARB_LOCK_EN
   input  logic            lock,
`endif
   output logic [NREQ-1:0] gnt,
   output logic [3:0]      gnt_num,
   output logic            busy,
   output logic            tmo
);

   localparam logic [TMOW-1:0] TmoLast = (TMO == 0) ? '0 : TMOW'(TMO - 1);

   state_e          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [3:0]      gnt_num_q, gnt_num_d;
   logic [3:0]      last_q, last_d;
   logic [TMOW-1:0] cnt_q, cnt_d;
   logic            tmo_q, tmo_d;

   logic [NREQ-1:0] mreq;
   logic [3:0]      midx, ridx, sel;
   logic            locked;
   logic            normal_rel;
   logic            tmo_hit;

`ifdef FLO12_RR_ARB_LOCK_EN
   assign locked = lock;
`else
   assign locked = 1'b0;
`endif

   assign mreq = req & below_mask(last_q);

   flo12_rr_arb_flo u_flo_masked (
      .vec (mreq),
      .idx (midx)
   );

   flo12_rr_arb_flo u_flo_full (
      .vec (req),
      .idx (ridx)
   );

   // Nothing below the last grant wraps the search back to the top index.
   assign sel = (midx != NONE) ? midx : ridx;

   assign normal_rel = done | ~(|(req & gnt_q));
   assign tmo_hit    = (TMO != 0) && (cnt_q == TmoLast);

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_num_d = gnt_num_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      tmo_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (|req) begin
               state_d   = StGrant;
               gnt_d     = NREQ'(1) << sel;
               gnt_num_d = sel;
               last_d    = sel;
               cnt_d     = '0;
            end
         end
         StGrant: begin
            if (locked) begin
               cnt_d = cnt_q;
            end else if (normal_rel || tmo_hit) begin
               state_d   = StIdle;
               gnt_d     = '0;
               gnt_num_d = NONE;
               tmo_d     = ~normal_rel;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + TMOW'(1);
            end
         end
         default: begin
            state_d   = StIdle;
            gnt_d     = '0;
            gnt_num_d = NONE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         gnt_q     <= '0;
         gnt_num_q <= NONE;
         last_q    <= NONE;
         cnt_q     <= '0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_num_q <= gnt_num_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_num = gnt_num_q;
   assign busy    = (state_q == StGrant);
   assign tmo     = tmo_q;

endmodule
